imem_arbiter: RTL and testbench
===============================

# imem_arbiter

Arbitrates the single combinational instruction ROM port between two requesters: port 0 is the IF-stage instruction fetch, and port 1 is the data-side read path used for loads from the text segment and by the test loader. It accepts at most one request per cycle and drives the ROM chip-enable and address for that request. It registers the ROM output into a response slot held under valid/ready back-pressure, and rejects misaligned or out-of-range addresses with an error response. It sits between the fetch/memory stages and the ROM; the ROM itself is unchanged.

## Interface
Parameters:
- MEM_WORDS, default `InstMemNum`: ROM depth in 32-bit words.
- ADDR_LSB_W, default `InstMemNumLog2`: word-index width.

Ports (one clock; reset is asynchronous and active-low):
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_i, in, 2: per-port request; must be held until the matching gnt_o bit is seen.
- addr0_i, in, 32: port 0 byte address.
- addr1_i, in, 32: port 1 byte address.
- gnt_o, out, 2: one-hot or zero, combinational; the request is accepted this cycle.
- flush_i, in, 1: pipeline flush; discards port-0 traffic.
- rsp_valid_o, out, 1: response slot full.
- rsp_id_o, out, 1: port the response belongs to.
- rsp_data_o, out, 32: instruction word.
- rsp_err_o, out, 1: misaligned or out-of-range access.
- rsp_ready_i, in, 1: consumer accepts the response.
- rom_ce_o, out, 1: ROM chip enable (`ChipEnable`/`ChipDisable`).
- rom_addr_o, out, 32: ROM byte address.
- rom_inst_i, in, 32: combinational ROM data.

## Operation
- State: response slot {valid, id, data, err} plus round-robin pointer `last` (1 bit).
- Slot "free" = !rsp_valid_o || rsp_ready_i. Grants happen only when the slot is free.
- Eligible ports = req_i & ~{1'b0, flush_i}. A flushed cycle never grants port 0.
- Arbitration:
  - One eligible port: grant it.
  - Both eligible: grant !last (round robin, see Configuration).
  - `last` updates to the granted id on every grant.
- Granted cycle:
  - Legal access: rom_ce_o=`ChipEnable`, rom_addr_o = selected address.
  - Error access (addr[1:0]!=0 or addr[31:2] >= MEM_WORDS): rom_ce_o=`ChipDisable`.
- No grant: rom_ce_o=`ChipDisable`, rom_addr_o=`ZeroWord`.
- Slot load on a grant edge:
  - valid=1, id = granted port.
  - Legal access: data=rom_inst_i, err=0.
  - Error access: data=`ZeroWord`, err=1.
- Slot clear: when rsp_ready_i is high with no new grant, valid clears.
- Flush: if flush_i is high and the slot holds id 0, the slot clears at the next edge whether or not rsp_ready_i is high. A slot holding id 1 is unaffected.
- Reset (async, any time): all slot fields, gnt_o, and rom_ce_o go to 0 / `ChipDisable`; last=1, so port 0 wins the first tie. An in-flight response is lost.

## Timing
- Latency: request granted in cycle N → rsp_valid_o in cycle N+1.
- Throughput: one response per cycle while rsp_ready_i stays high.
- Back-pressure: rsp_valid_o && !rsp_ready_i → gnt_o=0 and rom_ce_o disabled. Slot contents are held stable until accepted.
- Simultaneous rsp_ready_i and new grant: the old response is consumed and the new one is loaded at the same edge; rsp_valid_o stays 1.
- Simultaneous flush_i and a port-0 slot while rsp_ready_i is high: the slot clears; port 1 may still be granted and loaded.
- gnt_o, rom_ce_o and rom_addr_o are combinational from req_i, addresses, flush_i and slot state. The response outputs are registered.

## Configuration
- IMEM_ARB_RR_EN defined: round-robin tie-break as above.
- IMEM_ARB_RR_EN undefined: fixed priority, port 0 always wins ties; `last` is not implemented.

## Structure
- `imem_pkg`:
  - `imem_port_e` enum (IMEM_PORT_FETCH=0, IMEM_PORT_DATA=1).
  - Response struct typedef {valid, id, data, err}.
  - Error-check function `imem_addr_bad(addr)`.
- Existing `defines.svh` macros (`InstAddrBus`, `InstBus`, `ZeroWord`, `ChipEnable`) are reused.
- Sub-module: `arb2_rr`, a two-requester arbiter with enable and optional pointer, instantiated once.

## Test plan
- Reset release, then req_i=01, addr0=0x0000_0004 → gnt_o=01 and rom_addr_o=4 the same cycle; next cycle rsp_valid=1, id=0, data=mem[1], err=0.
- req_i=11 held for 4 cycles, rsp_ready=1 → grants 01,10,01,10 (RR); without IMEM_ARB_RR_EN, grants 01,01,01,01.
- Response pending with rsp_ready=0 for 3 cycles while req_i=01 → gnt_o=0 and rom_ce disabled throughout, rsp_data stable; ready=1 → next grant in that cycle.
- addr1=0x0000_0006 → rom_ce disabled, next cycle rsp_err=1, rsp_data=0, id=1. Also addr0=MEM_WORDS*4 → err=1.
- Slot holds id 0, rsp_ready=0, flush_i=1 with req_i=11 → slot cleared next cycle, port 1 granted once the slot is free, port 0 not granted during flush.
- Slot valid, rst_n pulled low mid-cycle → rsp_valid_o=0 and rom_ce_o disabled immediately; first tie after release goes to port 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
// Constants mirror the legacy defines (InstMemNum, ZeroWord, ChipEnable, ...).
package imem_pkg;

    localparam int unsigned INST_MEM_NUM      = 4096;
    localparam int unsigned INST_MEM_NUM_LOG2 = 12;
    localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;
    localparam logic        CHIP_ENABLE       = 1'b1;
    localparam logic        CHIP_DISABLE      = 1'b0;

    typedef enum logic {
        IMEM_PORT_FETCH = 1'b0,
        IMEM_PORT_DATA  = 1'b1
    } imem_port_e;

    typedef struct packed {
        logic        valid;
        imem_port_e  id;
        logic [31:0] data;
        logic        err;
    } imem_rsp_t;

    // Word index must be aligned, fit in idx_w bits and lie below the ROM depth.
    function automatic logic imem_addr_bad(
        input logic [31:0] addr,
        input int unsigned words = INST_MEM_NUM,
        input int unsigned idx_w = INST_MEM_NUM_LOG2
    );
        logic [31:0] idx;
        idx = {2'b00, addr[31:2]};
        return (addr[1:0] != 2'b00) || ((idx >> idx_w) != '0) || (idx >= words);
    endfunction

endpackage

// File: rtl/imem_arbiter_arb2_rr.sv
// Two-requester arbiter with enable; round-robin pointer when IMEM_ARB_RR_EN
// is defined, fixed priority (port 0 wins) otherwise.
module arb2_rr (
`ifdef IMEM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst_n,
`endif
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic [1:0] tie_gnt;

`ifdef IMEM_ARB_RR_EN
    logic last;

    // Reset to 1 so the first tie goes to port 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= 1'b1;
        end else if (|gnt) begin
            last <= gnt[1];
        end
    end

    assign tie_gnt = last ? 2'b01 : 2'b10;
`else
    assign tie_gnt = 2'b01;
`endif

    always_comb begin
        gnt = '0;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = tie_gnt;
                default: gnt = '0;
            endcase
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Arbitrates the instruction ROM between fetch (port 0) and data reads (port 1),
// registering one response slot. Tie-break mode selected by IMEM_ARB_RR_EN.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = INST_MEM_NUM,
    parameter int unsigned ADDR_LSB_W = INST_MEM_NUM_LOG2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    output logic [1:0]  gnt_o,
    input  logic        flush_i,
    output logic        rsp_valid_o,
    output logic        rsp_id_o,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    input  logic        rsp_ready_i,
    output logic        rom_ce_o,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_inst_i
);

    imem_rsp_t   slot;
    logic        slot_free;
    logic [1:0]  eligible;
    logic [1:0]  gnt;
    logic        granted;
    logic        bad;
    logic [31:0] sel_addr;
    imem_port_e  gnt_id;

    assign slot_free = !slot.valid || rsp_ready_i;
    assign eligible  = req_i & {1'b1, ~flush_i};

    // Enable is gated by rst_n so no grant is visible while reset is asserted.
    arb2_rr u_arb (
`ifdef IMEM_ARB_RR_EN
        .clk   (clk),
        .rst_n (rst_n),
`endif
        .en    (slot_free && rst_n),
        .req   (eligible),
        .gnt   (gnt)
    );

    always_comb begin
        granted    = |gnt;
        gnt_id     = gnt[1] ? IMEM_PORT_DATA : IMEM_PORT_FETCH;
        sel_addr   = gnt[1] ? addr1_i : addr0_i;
        bad        = imem_addr_bad(sel_addr, MEM_WORDS, ADDR_LSB_W);
        rom_ce_o   = (granted && !bad) ? CHIP_ENABLE : CHIP_DISABLE;
        rom_addr_o = granted ? sel_addr : ZERO_WORD;
    end

    assign gnt_o = gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (granted) begin
            slot.valid <= 1'b1;
            slot.id    <= gnt_id;
            slot.data  <= bad ? ZERO_WORD : rom_inst_i;
            slot.err   <= bad;
        end else if (rsp_ready_i || (flush_i && slot.id == IMEM_PORT_FETCH)) begin
            slot.valid <= 1'b0;
        end
    end

    assign rsp_valid_o = slot.valid;
    assign rsp_id_o    = slot.id;
    assign rsp_data_o  = slot.data;
    assign rsp_err_o   = slot.err;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed vector table, reset and
// tie-break sequences, then random traffic against a behavioural model.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int unsigned MW = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_i = '0;
    logic [31:0] addr0_i = '0;
    logic [31:0] addr1_i = '0;
    logic        flush_i = 1'b0;
    logic        rsp_ready_i = 1'b0;
    logic [1:0]  gnt_o;
    logic        rsp_valid_o;
    logic        rsp_id_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        rom_ce_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_inst_i;

    always #5 clk = ~clk;

    imem_arbiter #(.MEM_WORDS(MW), .ADDR_LSB_W(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_i       (req_i),
        .addr0_i     (addr0_i),
        .addr1_i     (addr1_i),
        .gnt_o       (gnt_o),
        .flush_i     (flush_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .rsp_ready_i (rsp_ready_i),
        .rom_ce_o    (rom_ce_o),
        .rom_addr_o  (rom_addr_o),
        .rom_inst_i  (rom_inst_i)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        return {16'hC0DE, idx[15:0]};
    endfunction

    // ROM returns garbage when disabled so error responses must not latch it.
    assign rom_inst_i = rom_ce_o ? rom_word({2'b00, rom_addr_o[31:2]}) : 32'hDEAD_BEEF;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: response slot and last winner.
    bit          m_valid;
    int          m_id;
    logic [31:0] m_data;
    bit          m_err;
`ifdef IMEM_ARB_RR_EN
    int          m_last;
`endif

    task automatic model_reset();
        m_valid = 0; m_id = 0; m_data = '0; m_err = 0;
`ifdef IMEM_ARB_RR_EN
        m_last = 1;
`endif
    endtask

    function automatic bit addr_illegal(input logic [31:0] a);
        return (a % 4 != 0) || ((a / 4) >= MW);
    endfunction

    function automatic int pick_port(input logic [1:0] req, input bit fl, input bit rdy);
        bit e0, e1;
        if (!rst_n || (m_valid && !rdy)) return -1;
        e0 = req[0] && !fl;
        e1 = req[1];
        if (e0 && e1) begin
`ifdef IMEM_ARB_RR_EN
            return (m_last == 1) ? 0 : 1;
`else
            return 0;
`endif
        end
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    task automatic model_advance(input int g);
        logic [31:0] a;
        if (g >= 0) begin
            a = (g == 0) ? addr0_i : addr1_i;
            m_valid = 1;
            m_id = g;
            m_err = addr_illegal(a);
            m_data = m_err ? 32'h0 : rom_word(a / 4);
`ifdef IMEM_ARB_RR_EN
            m_last = g;
`endif
        end else if (rsp_ready_i || (flush_i && m_id == 0)) begin
            m_valid = 0;
        end
    endtask

    // Drive one cycle from posedge+1; check at negedge against the model.
    task automatic apply(input logic [1:0] req, input logic [31:0] a0, input logic [31:0] a1,
                         input logic fl, input logic rdy, output logic [1:0] seen_gnt);
        int g;
        logic [31:0] a;
        req_i = req; addr0_i = a0; addr1_i = a1; flush_i = fl; rsp_ready_i = rdy;
        #4;
        g = pick_port(req, fl, rdy);
        a = (g == 1) ? a1 : a0;
        seen_gnt = gnt_o;
        chk("gnt", {30'b0, gnt_o}, (g < 0) ? 32'd0 : ((g == 0) ? 32'd1 : 32'd2));
        chk("rom_ce", {31'b0, rom_ce_o}, {31'b0, (g >= 0) && !addr_illegal(a)});
        chk("rom_addr", rom_addr_o, (g >= 0) ? a : 32'h0);
        chk("rsp_valid", {31'b0, rsp_valid_o}, {31'b0, m_valid});
        if (m_valid) begin
            chk("rsp_id", {31'b0, rsp_id_o}, m_id);
            chk("rsp_data", rsp_data_o, m_data);
            chk("rsp_err", {31'b0, rsp_err_o}, {31'b0, m_err});
        end
        model_advance(g);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        fl;
        logic        rdy;
        logic [1:0]  gnt;
        logic        ce;
        logic [31:0] addr;
        logic        v;
        logic        id;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t tab[16];
    logic [1:0] g_seen;
    logic [1:0] tie_exp[4];

    initial begin
        // Expected slot columns describe the slot during that row's cycle.
        tab[0]  = '{2'b01, 32'd4,   32'd0,  1'b0, 1'b1, 2'b01, 1'b1, 32'd4,   1'b0, 1'b0, 32'h0,         1'b0};
        tab[1]  = '{2'b00, 32'd0,   32'd0,  1'b0, 1'b0, 2'b00, 1'b0, 32'd0,   1'b1, 1'b0, 32'hC0DE_0001, 1'b0};
        tab[2]  = '{2'b01, 32'd8,   32'd0,  1'b0, 1'b0, 2'b00, 1'b0, 32'd0,   1'b1, 1'b0, 32'hC0DE_0001, 1'b0};
        tab[3]  = '{2'b01, 32'd8,   32'd0,  1'b0, 1'b0, 2'b00, 1'b0, 32'd0,   1'b1, 1'b0, 32'hC0DE_0001, 1'b0};
        tab[4]  = '{2'b01, 32'd8,   32'd0,  1'b0, 1'b1, 2'b01, 1'b1, 32'd8,   1'b1, 1'b0, 32'hC0DE_0001, 1'b0};
        tab[5]  = '{2'b10, 32'd0,   32'd6,  1'b0, 1'b1, 2'b10, 1'b0, 32'd6,   1'b1, 1'b0, 32'hC0DE_0002, 1'b0};
        tab[6]  = '{2'b01, 32'd252, 32'd0,  1'b0, 1'b1, 2'b01, 1'b1, 32'd252, 1'b1, 1'b1, 32'h0,         1'b1};
        tab[7]  = '{2'b01, 32'd256, 32'd0,  1'b0, 1'b1, 2'b01, 1'b0, 32'd256, 1'b1, 1'b0, 32'hC0DE_003F, 1'b0};
        tab[8]  = '{2'b01, 32'd12,  32'd0,  1'b0, 1'b1, 2'b01, 1'b1, 32'd12,  1'b1, 1'b0, 32'h0,         1'b1};
        tab[9]  = '{2'b11, 32'd16,  32'd20, 1'b1, 1'b0, 2'b00, 1'b0, 32'd0,   1'b1, 1'b0, 32'hC0DE_0003, 1'b0};
        tab[10] = '{2'b11, 32'd16,  32'd20, 1'b1, 1'b0, 2'b10, 1'b1, 32'd20,  1'b0, 1'b0, 32'h0,         1'b0};
        tab[11] = '{2'b00, 32'd0,   32'd0,  1'b1, 1'b0, 2'b00, 1'b0, 32'd0,   1'b1, 1'b1, 32'hC0DE_0005, 1'b0};
        tab[12] = '{2'b01, 32'd16,  32'd0,  1'b0, 1'b0, 2'b00, 1'b0, 32'd0,   1'b1, 1'b1, 32'hC0DE_0005, 1'b0};
        tab[13] = '{2'b01, 32'd16,  32'd0,  1'b0, 1'b1, 2'b01, 1'b1, 32'd16,  1'b1, 1'b1, 32'hC0DE_0005, 1'b0};
        tab[14] = '{2'b00, 32'd0,   32'd0,  1'b0, 1'b1, 2'b00, 1'b0, 32'd0,   1'b1, 1'b0, 32'hC0DE_0004, 1'b0};
        tab[15] = '{2'b00, 32'd0,   32'd0,  1'b0, 1'b0, 2'b00, 1'b0, 32'd0,   1'b0, 1'b0, 32'h0,         1'b0};
`ifdef IMEM_ARB_RR_EN
        tie_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        tie_exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif

        model_reset();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("reset_gnt", {30'b0, gnt_o}, 32'd0);
        chk("reset_ce", {31'b0, rom_ce_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            req_i = tab[i].req; addr0_i = tab[i].a0; addr1_i = tab[i].a1;
            flush_i = tab[i].fl; rsp_ready_i = tab[i].rdy;
            #4;
            chk($sformatf("vec%0d_gnt", i), {30'b0, gnt_o}, {30'b0, tab[i].gnt});
            chk($sformatf("vec%0d_ce", i), {31'b0, rom_ce_o}, {31'b0, tab[i].ce});
            if (tab[i].gnt != 2'b00 && tab[i].ce)
                chk($sformatf("vec%0d_addr", i), rom_addr_o, tab[i].addr);
            if (tab[i].gnt == 2'b00)
                chk($sformatf("vec%0d_addr", i), rom_addr_o, 32'h0);
            chk($sformatf("vec%0d_valid", i), {31'b0, rsp_valid_o}, {31'b0, tab[i].v});
            if (tab[i].v) begin
                chk($sformatf("vec%0d_id", i), {31'b0, rsp_id_o}, {31'b0, tab[i].id});
                chk($sformatf("vec%0d_data", i), rsp_data_o, tab[i].data);
                chk($sformatf("vec%0d_err", i), {31'b0, rsp_err_o}, {31'b0, tab[i].err});
            end
            model_advance(pick_port(req_i, flush_i, rsp_ready_i));
            @(posedge clk);
            #1;
        end

        // Asynchronous reset mid-cycle with a response pending.
        apply(2'b01, 32'd0, 32'd4, 1'b0, 1'b1, g_seen);
        req_i = 2'b11; rsp_ready_i = 1'b0;
        #2;
        chk("pre_reset_valid", {31'b0, rsp_valid_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", {31'b0, rsp_valid_o}, 32'd0);
        chk("async_reset_ce", {31'b0, rom_ce_o}, 32'd0);
        chk("async_reset_gnt", {30'b0, gnt_o}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Sustained tie after reset release.
        for (int i = 0; i < 4; i++) begin
            apply(2'b11, 32'd0, 32'd4, 1'b0, 1'b1, g_seen);
            chk($sformatf("tie%0d_gnt", i), {30'b0, g_seen}, {30'b0, tie_exp[i]});
        end

        for (int i = 0; i < 1500; i++) begin
            logic [31:0] a[2];
            for (int p = 0; p < 2; p++) begin
                case ($urandom_range(0, 9))
                    7:       a[p] = $urandom_range(0, MW - 1) * 4 + $urandom_range(1, 3);
                    8:       a[p] = MW * 4 + $urandom_range(0, 15) * 4;
                    9:       a[p] = $urandom;
                    default: a[p] = $urandom_range(0, MW - 1) * 4;
                endcase
            end
            apply(2'($urandom_range(0, 3)), a[0], a[1], $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) != 0, g_seen);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
